// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter: zero-fills a single-port masked SRAM after reset, then
// round-robin arbitrates two requesters with buffered per-requester read responses.
module sram_port_arbiter #(
   parameter int ADDR_W  = 6,
   parameter int DATA_W  = 32,
   parameter int MASK_W  = 4,
   parameter int INIT_EN = 1
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              req0_valid,
   output logic              req0_ready,
   input  logic              req0_write,
   input  logic [ADDR_W-1:0] req0_addr,
   input  logic [DATA_W-1:0] req0_wdata,
   input  logic [MASK_W-1:0] req0_wmask,
   output logic              rsp0_valid,
   output logic [DATA_W-1:0] rsp0_rdata,
   input  logic              rsp0_ready,
   input  logic              req1_valid,
   output logic              req1_ready,
   input  logic              req1_write,
   input  logic [ADDR_W-1:0] req1_addr,
   input  logic [DATA_W-1:0] req1_wdata,
   input  logic [MASK_W-1:0] req1_wmask,
   output logic              rsp1_valid,
   output logic [DATA_W-1:0] rsp1_rdata,
   input  logic              rsp1_ready,
   output logic              init_done,
   output logic              RW0_en,
   output logic              RW0_wmode,
   output logic [ADDR_W-1:0] RW0_addr,
   output logic [MASK_W-1:0] RW0_wmask,
   output logic [DATA_W-1:0] RW0_wdata,
   input  logic [DATA_W-1:0] RW0_rdata
);
   localparam int DEPTH = 1 << ADDR_W;
   localparam logic [0:0] S_INIT = 1'b0;
   localparam logic [0:0] S_RUN  = 1'b1;

   logic [0:0]        r_state;
   logic [ADDR_W-1:0] r_cnt;
   logic              r_ptr;
   logic [1:0]        r_rd_pend;
   logic [1:0]        r_rsp_valid;
   logic [DATA_W-1:0] r_rdata0, r_rdata1;
   logic              w_init, w_run, w_elig0, w_elig1, w_gnt0, w_gnt1;

   // Reset gates the port so the macro sees no access during the reset cycle.
   assign w_init  = (r_state == S_INIT) && !reset;
   assign w_run   = (r_state == S_RUN) && !reset;
   // A read is only eligible when its response slot is free or being drained now.
   assign w_elig0 = req0_valid && (req0_write || (!r_rd_pend[0] && (!r_rsp_valid[0] || rsp0_ready)));
   assign w_elig1 = req1_valid && (req1_write || (!r_rd_pend[1] && (!r_rsp_valid[1] || rsp1_ready)));
   assign w_gnt0  = w_run && w_elig0 && (!w_elig1 || !r_ptr);
   assign w_gnt1  = w_run && w_elig1 && (!w_elig0 || r_ptr);

   assign req0_ready = w_gnt0;
   assign req1_ready = w_gnt1;
   assign rsp0_valid = r_rsp_valid[0];
   assign rsp1_valid = r_rsp_valid[1];
   assign rsp0_rdata = r_rdata0;
   assign rsp1_rdata = r_rdata1;
   assign init_done  = r_state == S_RUN;

   assign RW0_en    = w_init || w_gnt0 || w_gnt1;
   assign RW0_wmode = w_init || (w_gnt0 ? req0_write : w_gnt1 && req1_write);
   assign RW0_addr  = w_init ? r_cnt : w_gnt0 ? req0_addr : w_gnt1 ? req1_addr : '0;
   assign RW0_wmask = w_init ? '1 : w_gnt0 ? req0_wmask : w_gnt1 ? req1_wmask : '0;
   assign RW0_wdata = w_gnt0 ? req0_wdata : w_gnt1 ? req1_wdata : '0;

   always_ff @(posedge clock) begin
      if (reset) begin
         r_state     <= (INIT_EN != 0) ? S_INIT : S_RUN;
         r_cnt       <= '0;
         r_ptr       <= 1'b0;
         r_rd_pend   <= '0;
         r_rsp_valid <= '0;
         r_rdata0    <= '0;
         r_rdata1    <= '0;
      end else begin
         if (r_state == S_INIT) begin
            r_cnt <= r_cnt + 1'b1;
            if (r_cnt == ADDR_W'(DEPTH - 1)) r_state <= S_RUN;
         end
         if (w_gnt0 || w_gnt1) r_ptr <= w_gnt0;
         r_rd_pend      <= {w_gnt1 && !req1_write, w_gnt0 && !req0_write};
         r_rsp_valid[0] <= r_rd_pend[0] || (r_rsp_valid[0] && !rsp0_ready);
         r_rsp_valid[1] <= r_rd_pend[1] || (r_rsp_valid[1] && !rsp1_ready);
         if (r_rd_pend[0]) r_rdata0 <= RW0_rdata;
         if (r_rd_pend[1]) r_rdata1 <= RW0_rdata;
      end
   end
endmodule

// File: tb/tb_sram_port_arbiter.sv
// tb_sram_port_arbiter: directed bench with a response scoreboard and a behavioural
// 64x32 masked SRAM behind each arbiter (one zero-filling, one with INIT_EN=0).
module tb_sram_port_arbiter;
   logic        clock, reset;
   logic        req0_valid, req0_write, req1_valid, req1_write, rsp0_ready, rsp1_ready;
   logic [5:0]  req0_addr, req1_addr;
   logic [31:0] req0_wdata, req1_wdata;
   logic [3:0]  req0_wmask, req1_wmask;
   logic        req0_ready, req1_ready, rsp0_valid, rsp1_valid, init_done;
   logic [31:0] rsp0_rdata, rsp1_rdata;
   logic        rw_en, rw_wmode;
   logic [5:0]  rw_addr;
   logic [3:0]  rw_wmask;
   logic [31:0] rw_wdata, rw_rdata;
   logic        n_req0_ready, n_req1_ready, n_rsp0_valid, n_rsp1_valid, n_init_done;
   logic [31:0] n_rsp0_rdata, n_rsp1_rdata;
   logic        n_rw_en, n_rw_wmode;
   logic [5:0]  n_rw_addr;
   logic [3:0]  n_rw_wmask;
   logic [31:0] n_rw_wdata, n_rw_rdata;
   logic [31:0] mem [64];
   logic [31:0] n_mem [64];
   logic [31:0] q0 [$];
   logic [31:0] q1 [$];
   int          n_assert, n_fail;

   sram_port_arbiter #(.INIT_EN(1)) dut (
      .clock(clock), .reset(reset),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_write(req0_write),
      .req0_addr(req0_addr), .req0_wdata(req0_wdata), .req0_wmask(req0_wmask),
      .rsp0_valid(rsp0_valid), .rsp0_rdata(rsp0_rdata), .rsp0_ready(rsp0_ready),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_write(req1_write),
      .req1_addr(req1_addr), .req1_wdata(req1_wdata), .req1_wmask(req1_wmask),
      .rsp1_valid(rsp1_valid), .rsp1_rdata(rsp1_rdata), .rsp1_ready(rsp1_ready),
      .init_done(init_done), .RW0_en(rw_en), .RW0_wmode(rw_wmode), .RW0_addr(rw_addr),
      .RW0_wmask(rw_wmask), .RW0_wdata(rw_wdata), .RW0_rdata(rw_rdata)
   );

   sram_port_arbiter #(.INIT_EN(0)) dut_n (
      .clock(clock), .reset(reset),
      .req0_valid(req0_valid), .req0_ready(n_req0_ready), .req0_write(req0_write),
      .req0_addr(req0_addr), .req0_wdata(req0_wdata), .req0_wmask(req0_wmask),
      .rsp0_valid(n_rsp0_valid), .rsp0_rdata(n_rsp0_rdata), .rsp0_ready(rsp0_ready),
      .req1_valid(req1_valid), .req1_ready(n_req1_ready), .req1_write(req1_write),
      .req1_addr(req1_addr), .req1_wdata(req1_wdata), .req1_wmask(req1_wmask),
      .rsp1_valid(n_rsp1_valid), .rsp1_rdata(n_rsp1_rdata), .rsp1_ready(rsp1_ready),
      .init_done(n_init_done), .RW0_en(n_rw_en), .RW0_wmode(n_rw_wmode), .RW0_addr(n_rw_addr),
      .RW0_wmask(n_rw_wmask), .RW0_wdata(n_rw_wdata), .RW0_rdata(n_rw_rdata)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Macro models; reset leaves recognisable junk so the zero-fill is observable.
   always @(posedge clock) begin
      if (reset) begin
         for (int i = 0; i < 64; i++) mem[i] <= 32'hA5A50000 | 32'(i);
      end else if (rw_en) begin
         if (rw_wmode) begin
            for (int k = 0; k < 4; k++) if (rw_wmask[k]) mem[rw_addr][8*k +: 8] <= rw_wdata[8*k +: 8];
         end else rw_rdata <= mem[rw_addr];
      end
   end

   always @(posedge clock) begin
      if (reset) begin
         for (int j = 0; j < 64; j++) n_mem[j] <= 32'h12345670 + 32'(j);
      end else if (n_rw_en) begin
         if (n_rw_wmode) begin
            for (int m = 0; m < 4; m++) if (n_rw_wmask[m]) n_mem[n_rw_addr][8*m +: 8] <= n_rw_wdata[8*m +: 8];
         end else n_rw_rdata <= n_mem[n_rw_addr];
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic sb();
      if (rsp0_valid && rsp0_ready) begin
         if (q0.size() == 0) chk("rsp0_unexpected", 32'(rsp0_valid), 32'd0);
         else chk("rsp0_data", rsp0_rdata, q0.pop_front());
      end
      if (rsp1_valid && rsp1_ready) begin
         if (q1.size() == 0) chk("rsp1_unexpected", 32'(rsp1_valid), 32'd0);
         else chk("rsp1_data", rsp1_rdata, q1.pop_front());
      end
   endtask

   task automatic neg();
      @(negedge clock);
      sb();
   endtask

   task automatic pos();
      @(posedge clock);
      #1;
   endtask

   task automatic rq0(input logic v, input logic w, input logic [5:0] a, input logic [31:0] d, input logic [3:0] m);
      req0_valid = v; req0_write = w; req0_addr = a; req0_wdata = d; req0_wmask = m;
   endtask

   task automatic rq1(input logic v, input logic w, input logic [5:0] a, input logic [31:0] d, input logic [3:0] m);
      req1_valid = v; req1_write = w; req1_addr = a; req1_wdata = d; req1_wmask = m;
   endtask

   initial begin
      n_assert = 0;
      n_fail = 0;
      reset = 1'b1;
      rsp0_ready = 1'b1;
      rsp1_ready = 1'b1;
      rq0(1'b0, 1'b0, 6'd0, 32'd0, 4'h0);
      rq1(1'b0, 1'b0, 6'd0, 32'd0, 4'h0);
      repeat (2) pos();
      neg();
      chk("rst_en", 32'(rw_en), 32'd0);
      chk("rst_ready", 32'(req0_ready), 32'd0);
      chk("rst_rsp_valid", 32'(rsp0_valid), 32'd0);
      chk("rst_rdata", rsp0_rdata, 32'd0);
      chk("rst_init_done", 32'(init_done), 32'd0);
      chk("rst_n_init_done", 32'(n_init_done), 32'd1);
      pos();
      reset = 1'b0;
      rq0(1'b1, 1'b0, 6'd3, 32'd0, 4'h0);
      for (int i = 0; i < 64; i++) begin
         neg();
         chk("init_en", 32'(rw_en), 32'd1);
         chk("init_wmode", 32'(rw_wmode), 32'd1);
         chk("init_addr", 32'(rw_addr), 32'(i));
         chk("init_wdata", rw_wdata, 32'd0);
         chk("init_wmask", 32'(rw_wmask), 32'hf);
         chk("init_done_low", 32'(init_done), 32'd0);
         chk("init_no_grant", 32'(req0_ready), 32'd0);
         if (i == 0) begin
            chk("n_first_grant", 32'(n_req0_ready), 32'd1);
            chk("n_first_addr", 32'(n_rw_addr), 32'd3);
         end
         if (i == 1) chk("n_rsp_t1", 32'(n_rsp0_valid), 32'd0);
         if (i == 2) begin
            chk("n_rsp_t2", 32'(n_rsp0_valid), 32'd1);
            chk("n_rsp_data", n_rsp0_rdata, 32'h12345673);
         end
         pos();
         if (i == 0) rq0(1'b0, 1'b0, 6'd0, 32'd0, 4'h0);
      end
      rq0(1'b1, 1'b1, 6'd10, 32'hA0A0A0A0, 4'hf);
      rq1(1'b1, 1'b1, 6'd20, 32'hB1B1B1B1, 4'hf);
      for (int k = 0; k < 4; k++) begin
         neg();
         if (k == 0) chk("run_init_done", 32'(init_done), 32'd1);
         chk("alt_g0", 32'(req0_ready), (k % 2 == 0) ? 32'd1 : 32'd0);
         chk("alt_g1", 32'(req1_ready), (k % 2 == 1) ? 32'd1 : 32'd0);
         chk("alt_addr", 32'(rw_addr), (k % 2 == 1) ? 32'd20 : 32'd10);
         pos();
      end
      rq1(1'b0, 1'b0, 6'd0, 32'd0, 4'h0);
      rq0(1'b1, 1'b0, 6'd17, 32'd0, 4'h0);
      q0.push_back(32'h00000000);
      neg();
      chk("rd_grant", 32'(req0_ready), 32'd1);
      chk("rd_wmode", 32'(rw_wmode), 32'd0);
      chk("rd_addr", 32'(rw_addr), 32'd17);
      pos();
      rq0(1'b0, 1'b0, 6'd0, 32'd0, 4'h0);
      neg();
      chk("rd_lat_t1", 32'(rsp0_valid), 32'd0);
      pos();
      neg();
      chk("rd_lat_t2", 32'(rsp0_valid), 32'd1);
      pos();
      rq0(1'b1, 1'b1, 6'd5, 32'hDEADBEEF, 4'b0101);
      neg();
      chk("mw_grant", 32'(req0_ready), 32'd1);
      chk("mw_wmask", 32'(rw_wmask), 32'h5);
      pos();
      rq0(1'b1, 1'b1, 6'd5, 32'hFFFFFFFF, 4'h0);
      neg();
      chk("zw_grant", 32'(req0_ready), 32'd1);
      pos();
      rq0(1'b1, 1'b0, 6'd5, 32'd0, 4'h0);
      q0.push_back(32'h00AD00EF);
      neg();
      chk("mr_grant", 32'(req0_ready), 32'd1);
      pos();
      rq0(1'b0, 1'b0, 6'd0, 32'd0, 4'h0);
      neg();
      pos();
      neg();
      chk("mr_valid", 32'(rsp0_valid), 32'd1);
      pos();
      rsp1_ready = 1'b0;
      rq1(1'b1, 1'b0, 6'd20, 32'd0, 4'h0);
      q1.push_back(32'hB1B1B1B1);
      neg();
      chk("bp_rd_grant", 32'(req1_ready), 32'd1);
      pos();
      rq1(1'b0, 1'b0, 6'd0, 32'd0, 4'h0);
      neg();
      pos();
      rq1(1'b1, 1'b0, 6'd21, 32'd0, 4'h0);
      rq0(1'b1, 1'b1, 6'd30, 32'h30303030, 4'hf);
      for (int k = 0; k < 5; k++) begin
         neg();
         chk("bp_valid", 32'(rsp1_valid), 32'd1);
         chk("bp_data", rsp1_rdata, 32'hB1B1B1B1);
         chk("bp_rd_blocked", 32'(req1_ready), 32'd0);
         chk("bp_req0_grant", 32'(req0_ready), 32'd1);
         pos();
      end
      rq0(1'b0, 1'b0, 6'd0, 32'd0, 4'h0);
      rq1(1'b1, 1'b1, 6'd31, 32'h31313131, 4'hf);
      neg();
      chk("bp_wr_grant", 32'(req1_ready), 32'd1);
      chk("bp_valid_held", 32'(rsp1_valid), 32'd1);
      pos();
      rsp1_ready = 1'b1;
      rq1(1'b1, 1'b0, 6'd30, 32'd0, 4'h0);
      q1.push_back(32'h30303030);
      neg();
      chk("sc_grant", 32'(req1_ready), 32'd1);
      pos();
      rq1(1'b0, 1'b0, 6'd0, 32'd0, 4'h0);
      neg();
      chk("sc_gap", 32'(rsp1_valid), 32'd0);
      pos();
      neg();
      chk("sc_valid", 32'(rsp1_valid), 32'd1);
      pos();
      neg();
      chk("sb_drained", 32'(q0.size() + q1.size()), 32'd0);
      pos();
      reset = 1'b1;
      pos();
      reset = 1'b0;
      repeat (30) pos();
      reset = 1'b1;
      neg();
      chk("mid_rst_en", 32'(rw_en), 32'd0);
      pos();
      reset = 1'b0;
      for (int i = 0; i < 64; i++) begin
         neg();
         chk("refill_addr", 32'(rw_addr), 32'(i));
         chk("refill_done_low", 32'(init_done), 32'd0);
         pos();
      end
      neg();
      chk("refill_done", 32'(init_done), 32'd1);
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
